// File: rtl/board_pkg.sv
// Shared types and constants for the board move tracker.
// Imported by the tracker, its interface and the square decoder.
package board_pkg;

  localparam int NUM_SQUARES = 9;
  localparam int SQ_W        = 4;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  typedef logic [NUM_SQUARES:1] board_t;

endpackage

// File: rtl/board_move_tracker_if.sv
// Move request handshake between a move source and the tracker.
// master drives the request, slave answers with ready/ack/err.
interface board_move_tracker_if
  import board_pkg::*;
();

  logic            i_move_valid;
  logic            o_move_ready;
  logic [SQ_W-1:0] i_move_square;
  logic            o_move_ack;
  logic            o_move_err;

  modport master (
    output i_move_valid,
    output i_move_square,
    input  o_move_ready,
    input  o_move_ack,
    input  o_move_err
  );

  modport slave (
    input  i_move_valid,
    input  i_move_square,
    output o_move_ready,
    output o_move_ack,
    output o_move_err
  );

endinterface

// File: rtl/board_move_tracker_square_decode.sv
// Square number 1..9 to one-hot board mask plus a range-legal flag.
// Codes 0 and 10..15 decode to an empty mask and legal = 0.
module square_decode
  import board_pkg::*;
(
  input  logic [SQ_W-1:0] i_square,
  output board_t          o_onehot,
  output logic            o_legal
);

  always_comb begin
    o_onehot = '0;
    for (int i = 1; i <= NUM_SQUARES; i++) begin
      if (i_square == SQ_W'(i)) o_onehot[i] = 1'b1;
    end
  end

  assign o_legal = |o_onehot;

endmodule

// File: rtl/board_move_tracker.sv
// Tic-tac-toe move tracker feeding an external win checker.
// Optional single-level undo: define BOARD_MOVE_TRACKER_UNDO_EN.
module board_move_tracker
  import board_pkg::*;
#(
  parameter int FIRST_PLAYER = 1,
  parameter bit LOCK_ON_END  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_new_game,
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
  input  logic        i_undo,
`endif
  board_move_tracker_if.slave mv_if,
  output logic [9:1]  o_player_1_square_pos,
  output logic [9:1]  o_player_2_square_pos,
  input  logic        i_player_1_win,
  input  logic        i_player_2_win,
  output logic        o_turn,
  output logic        o_game_over,
  output logic [1:0]  o_result,
  output logic [3:0]  o_move_count
);

  localparam logic FIRST_TURN = (FIRST_PLAYER == 2);

  state_t  r_state, nx_state;
  board_t  r_p1, nx_p1;
  board_t  r_p2, nx_p2;
  logic [3:0] r_cnt, nx_cnt;
  result_t r_res, nx_res;
  logic    r_turn, nx_turn;

  board_t  w_sq_oh;
  logic    w_sq_legal;
  logic    w_ready;
  logic    w_hs;
  logic    w_ack;
  logic    w_err;
  logic    w_undo_req;
  logic    w_do_new;
  logic    w_do_undo;
  logic    w_do_check;
  logic    w_do_move;
  logic    w_do_restart;

  square_decode u_mv_dec (
    .i_square (mv_if.i_move_square),
    .o_onehot (w_sq_oh),
    .o_legal  (w_sq_legal)
  );

`ifdef BOARD_MOVE_TRACKER_UNDO_EN
  logic [SQ_W-1:0] r_last_sq, nx_last_sq;
  logic            r_last_p2, nx_last_p2;
  logic            r_undo_ok, nx_undo_ok;
  board_t          w_last_oh;
  logic            w_last_legal;

  square_decode u_undo_dec (
    .i_square (r_last_sq),
    .o_onehot (w_last_oh),
    .o_legal  (w_last_legal)
  );

  assign w_undo_req = i_undo;
`else
  assign w_undo_req = 1'b0;
`endif

  assign w_ready = (r_state == ST_PLAY) ||
                   ((r_state == ST_GAME_OVER) && !LOCK_ON_END);
  assign w_hs    = mv_if.i_move_valid && w_ready;

  // Arms below are mutually exclusive; new_game outranks everything.
  assign w_do_new     = i_new_game;
  assign w_do_undo    = !i_new_game && (r_state == ST_PLAY) &&
                        w_undo_req;
  assign w_do_check   = !i_new_game && (r_state == ST_CHECK);
  assign w_do_move    = !i_new_game && !w_undo_req &&
                        (r_state == ST_PLAY) && w_hs;
  assign w_do_restart = !i_new_game &&
                        (r_state == ST_GAME_OVER) && w_hs;

  always_comb begin
    nx_state = r_state;
    nx_p1    = r_p1;
    nx_p2    = r_p2;
    nx_cnt   = r_cnt;
    nx_res   = r_res;
    nx_turn  = r_turn;
    w_ack    = 1'b0;
    w_err    = 1'b0;
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
    nx_last_sq = r_last_sq;
    nx_last_p2 = r_last_p2;
    nx_undo_ok = r_undo_ok;
`endif
    unique case (1'b1)
      w_do_new: begin
        nx_state = ST_PLAY;
        nx_p1    = '0;
        nx_p2    = '0;
        nx_cnt   = 4'd0;
        nx_res   = RES_NONE;
        nx_turn  = FIRST_TURN;
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
        nx_undo_ok = 1'b0;
`endif
      end
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
      w_do_undo: begin
        if (r_cnt != 4'd0 && r_undo_ok && w_last_legal) begin
          if (r_last_p2) nx_p2 = r_p2 & ~w_last_oh;
          else           nx_p1 = r_p1 & ~w_last_oh;
          nx_cnt     = r_cnt - 4'd1;
          nx_turn    = r_last_p2;
          nx_undo_ok = 1'b0;
          w_ack      = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
`endif
      w_do_check: begin
        if (i_player_1_win) begin
          nx_res   = RES_P1;
          nx_state = ST_GAME_OVER;
        end else if (i_player_2_win) begin
          nx_res   = RES_P2;
          nx_state = ST_GAME_OVER;
        end else if (r_cnt == 4'd9) begin
          nx_res   = RES_DRAW;
          nx_state = ST_GAME_OVER;
        end else begin
          nx_state = ST_PLAY;
        end
      end
      w_do_move: begin
        if (w_sq_legal && !(|(w_sq_oh & (r_p1 | r_p2)))) begin
          if (r_turn) nx_p2 = r_p2 | w_sq_oh;
          else        nx_p1 = r_p1 | w_sq_oh;
          nx_cnt   = r_cnt + 4'd1;
          nx_turn  = !r_turn;
          nx_state = ST_CHECK;
          w_ack    = 1'b1;
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
          nx_last_sq = mv_if.i_move_square;
          nx_last_p2 = r_turn;
          nx_undo_ok = 1'b1;
`endif
        end else begin
          w_err = 1'b1;
        end
      end
      w_do_restart: begin
        // Board is wiped, so only the square range matters here.
        if (w_sq_legal) begin
          nx_p1    = FIRST_TURN ? '0 : w_sq_oh;
          nx_p2    = FIRST_TURN ? w_sq_oh : '0;
          nx_cnt   = 4'd1;
          nx_res   = RES_NONE;
          nx_turn  = !FIRST_TURN;
          nx_state = ST_CHECK;
          w_ack    = 1'b1;
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
          nx_last_sq = mv_if.i_move_square;
          nx_last_p2 = FIRST_TURN;
          nx_undo_ok = 1'b1;
`endif
        end else begin
          w_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_PLAY;
      r_p1    <= '0;
      r_p2    <= '0;
      r_cnt   <= 4'd0;
      r_res   <= RES_NONE;
      r_turn  <= FIRST_TURN;
    end else begin
      r_state <= nx_state;
      r_p1    <= nx_p1;
      r_p2    <= nx_p2;
      r_cnt   <= nx_cnt;
      r_res   <= nx_res;
      r_turn  <= nx_turn;
    end
  end

`ifdef BOARD_MOVE_TRACKER_UNDO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_sq <= '0;
      r_last_p2 <= 1'b0;
      r_undo_ok <= 1'b0;
    end else begin
      r_last_sq <= nx_last_sq;
      r_last_p2 <= nx_last_p2;
      r_undo_ok <= nx_undo_ok;
    end
  end
`endif

  assign mv_if.o_move_ready = w_ready;
  assign mv_if.o_move_ack   = w_ack & i_rst_n;
  assign mv_if.o_move_err   = w_err & i_rst_n;

  assign o_player_1_square_pos = r_p1;
  assign o_player_2_square_pos = r_p2;
  assign o_turn                = r_turn;
  assign o_game_over           = (r_state == ST_GAME_OVER);
  assign o_result              = r_res;
  assign o_move_count          = r_cnt;

`ifndef SYNTHESIS
  a_both_win : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !((r_state == ST_CHECK) && i_player_1_win && i_player_2_win)
  );
`endif

endmodule

// File: tb/tb_board_move_tracker.sv
// Bench for board_move_tracker: directed games plus random moves
// checked against an array-based game model and a behavioural checker.
module tb_board_move_tracker;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       p1w;
  logic       p2w;
  board_t     p1;
  board_t     p2;
  logic       turn;
  logic       over_o;
  logic [1:0] res;
  logic [3:0] cnt;
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
  logic       undo = 1'b0;
`endif

  board_move_tracker_if mv ();

  always #5 clk = ~clk;

  board_move_tracker #(
    .FIRST_PLAYER (1),
    .LOCK_ON_END  (1'b1)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_new_game            (new_game),
`ifdef BOARD_MOVE_TRACKER_UNDO_EN
    .i_undo                (undo),
`endif
    .mv_if                 (mv),
    .o_player_1_square_pos (p1),
    .o_player_2_square_pos (p2),
    .i_player_1_win        (p1w),
    .i_player_2_win        (p2w),
    .o_turn                (turn),
    .o_game_over           (over_o),
    .o_result              (res),
    .o_move_count          (cnt)
  );

  int LN [8][3] = '{
    '{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9},
    '{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9},
    '{1, 5, 9}, '{3, 5, 7}
  };

  function automatic logic has_line(board_t b);
    for (int l = 0; l < 8; l++) begin
      if (b[LN[l][0]] && b[LN[l][1]] && b[LN[l][2]])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Stand-in for the external checker.
  always_comb p1w = has_line(p1);
  always_comb p2w = has_line(p2);

  int own [1:9];
  int cur;
  int mcnt;
  int mres;
  bit mover;
  int total = 0;
  int bad = 0;

  function automatic board_t mboard(int who);
    board_t b;
    b = '0;
    for (int i = 1; i <= 9; i++) if (own[i] == who) b[i] = 1'b1;
    return b;
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 1; i <= 9; i++) own[i] = 0;
    cur   = 1;
    mcnt  = 0;
    mres  = 0;
    mover = 1'b0;
  endtask

  task automatic check_state();
    check("p1_pos", p1, mboard(1));
    check("p2_pos", p2, mboard(2));
    check("turn", turn, (cur == 2));
    check("count", cnt, mcnt);
    check("result", res, mres);
    check("game_over", over_o, mover);
  endtask

  task automatic attempt(input logic [3:0] sq, input bit ng,
                         output bit acc);
    bit rdy;
    bit legal;
    bit eack;
    bit eerr;
    int s;
    @(negedge clk);
    mv.i_move_valid  = 1'b1;
    mv.i_move_square = sq;
    new_game         = ng;
    #1;
    s     = int'(sq);
    legal = (s >= 1 && s <= 9);
    if (legal) legal = (own[s] == 0);
    rdy  = !mover;
    eack = !ng && rdy && legal;
    eerr = !ng && rdy && !legal;
    check("ready", mv.o_move_ready, rdy);
    check("ack", mv.o_move_ack, eack);
    check("err", mv.o_move_err, eerr);
    @(posedge clk);
    #1;
    mv.i_move_valid = 1'b0;
    new_game        = 1'b0;
    if (ng) model_clear();
    else if (eack) begin
      own[s] = cur;
      mcnt++;
      cur = 3 - cur;
    end
    acc = eack;
    check_state();
    if (eack) begin
      check("check_ready", mv.o_move_ready, 1'b0);
      @(posedge clk);
      #1;
      if (has_line(mboard(1)))      mres = 1;
      else if (has_line(mboard(2))) mres = 2;
      else if (mcnt == 9)           mres = 3;
      if (mres != 0) mover = 1'b1;
      check_state();
    end
  endtask

  initial begin
    bit acc;
    logic [3:0] sq;
    bit ng;
    logic [3:0] win_seq [5] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
    logic [3:0] draw_seq [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4,
                                 4'd6, 4'd8, 4'd7, 4'd9};
    mv.i_move_valid  = 1'b0;
    mv.i_move_square = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    check("rst_ack", mv.o_move_ack, 1'b0);
    check("rst_err", mv.o_move_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (win_seq[i]) attempt(win_seq[i], 1'b0, acc);
    check("p1_row", p1, 9'b000000111);
    check("p1_won", res, 2'b01);

    attempt(4'd0, 1'b1, acc);
    attempt(4'd5, 1'b0, acc);
    attempt(4'd5, 1'b0, acc);
    check("occ_turn", turn, 1'b1);
    attempt(4'd9, 1'b1, acc);
    check("ng_turn", turn, 1'b0);
    check("ng_p1", p1, 9'd0);

    attempt(4'd0, 1'b0, acc);
    attempt(4'd12, 1'b0, acc);
    check("bad_sq_cnt", cnt, 4'd0);

    foreach (draw_seq[i]) attempt(draw_seq[i], 1'b0, acc);
    check("draw_res", res, 2'b11);
    check("draw_cnt", cnt, 4'd9);
    check("draw_ready", mv.o_move_ready, 1'b0);
    attempt(4'd1, 1'b0, acc);

    attempt(4'd0, 1'b1, acc);
    @(negedge clk);
    mv.i_move_valid  = 1'b1;
    mv.i_move_square = 4'd7;
    @(posedge clk);
    #1;
    mv.i_move_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_state();
    check("rst_ready", mv.o_move_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    attempt(4'd7, 1'b0, acc);
    check("post_rst_acc", acc, 1'b1);
    check("post_rst_p1", p1, 9'b001000000);

    for (int n = 0; n < 400; n++) begin
      if (mover) ng = ($urandom_range(0, 3) == 0);
      else       ng = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        sq = 4'($urandom_range(0, 15));
      else
        sq = 4'($urandom_range(1, 9));
      attempt(sq, ng, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
